ext_bus_arbiter: RTL

- Shares the single external memory/peripheral bus (PIN_ADDR_BUS, PIN_DATA_BUS, RDN/WR0N/WR1N) between two requesters: port 0 = CPU core, port 1 = debug/loader port.
- Sequences every bus cycle as setup → strobe → hold with programmable wait states.
- Drives the address/data output enables, and returns read data plus a one-cycle ACK to the winning requester.
- Sits between core/debug logic and the pin tri-state buffers in the mcu top level.

---
 rtl/ext_bus_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ext_bus_arbiter.sv
// Two-port external bus arbiter: grants CPU (port 0) or debug (port 1) and
// sequences each bus cycle as setup -> strobe -> hold -> done with registered pin controls.
module ext_bus_arbiter #(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic        we0_i,
   input  logic        we1_i,
   input  logic [1:0]  be0_i,
   input  logic [1:0]  be1_i,
   input  logic [15:0] addr0_i,
   input  logic [15:0] addr1_i,
   input  logic [15:0] wdata0_i,
   input  logic [15:0] wdata1_i,
   output logic        ack0_o,
   output logic        ack1_o,
   output logic [15:0] rdata_o,
   output logic        busy_o,
   output logic [15:0] addr_buf_o,
   output logic [15:0] dout_buf_o,
   input  logic [15:0] din_bus_i,
   output logic        abus_oen_o,
   output logic        dbus_oen_o,
   output logic        rdn_o,
   output logic        wr0n_o,
   output logic        wr1n_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_e;

   localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic        we_q, we_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        abus_oen_q, abus_oen_d;
   logic        dbus_oen_q, dbus_oen_d;
   logic        rdn_q, rdn_d;
   logic        wr0n_q, wr0n_d;
   logic        wr1n_q, wr1n_d;
   logic        grant1;
   logic        drive_d;
   logic        strobe_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      grant1       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0_i || req1_i) begin
               // On contention the port that did not win last time gets the bus.
               grant1       = req1_i && (!req0_i || !last_owner_q);
               owner_d      = grant1;
               last_owner_d = grant1;
               we_d         = grant1 ? we1_i    : we0_i;
               be_d         = grant1 ? be1_i    : be0_i;
               addr_d       = grant1 ? addr1_i  : addr0_i;
               wdata_d      = grant1 ? wdata1_i : wdata0_i;
               cnt_d        = SETUP_LOAD;
               state_d      = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd0) begin
               if (we_q && (be_q == 2'b00)) begin
                  state_d = S_HOLD;
               end else begin
                  cnt_d   = STROBE_LOAD;
                  state_d = S_STROBE;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) begin
                  rdata_d = din_bus_i;
               end
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Pin controls are decoded from the next state so they come straight off flops.
      drive_d    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      strobe_d   = (state_d == S_STROBE);
      abus_oen_d = !drive_d;
      dbus_oen_d = !(drive_d && we_d);
      rdn_d      = !(strobe_d && !we_d);
      wr0n_d     = !(strobe_d && we_d && be_d[0]);
      wr1n_d     = !(strobe_d && we_d && be_d[1]);
      ack0_d     = (state_d == S_DONE) && !owner_d;
      ack1_d     = (state_d == S_DONE) && owner_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         we_q         <= 1'b0;
         be_q         <= 2'b00;
         addr_q       <= 16'h0000;
         wdata_q      <= 16'h0000;
         rdata_q      <= 16'h0000;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         abus_oen_q   <= 1'b1;
         dbus_oen_q   <= 1'b1;
         rdn_q        <= 1'b1;
         wr0n_q       <= 1'b1;
         wr1n_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         be_q         <= be_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         abus_oen_q   <= abus_oen_d;
         dbus_oen_q   <= dbus_oen_d;
         rdn_q        <= rdn_d;
         wr0n_q       <= wr0n_d;
         wr1n_q       <= wr1n_d;
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign ack0_o     = ack0_q;
   assign ack1_o     = ack1_q;
   assign rdata_o    = rdata_q;
   assign addr_buf_o = addr_q;
   assign dout_buf_o = wdata_q;
   assign abus_oen_o = abus_oen_q;
   assign dbus_oen_o = dbus_oen_q;
   assign rdn_o      = rdn_q;
   assign wr0n_o     = wr0n_q;
   assign wr1n_o     = wr1n_q;

endmodule
